hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage core.
- Produces the stall/flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage operand forwarding selects.
- Resolves RAW hazards by forwarding, load-use hazards by a 1-cycle stall plus bubble, and taken branches/jumps by flushing.
- Contains a data-memory wait FSM that freezes the pipeline while a load/store is unacknowledged, with a sticky timeout error.

---
 rtl/hazard_unit.sv | 155 +++++++++++++++
 tb/tb_hazard_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and data-memory wait FSM.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | no outstanding unacknowledged data-memory access
// WAIT  | load/store in Memory not yet acknowledged, counting wait cycles
// ERROR | memory wait timed out; pipeline frozen until reset
module hazard_unit #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           rs1_addr_d_i,
    input  logic [4:0]           rs2_addr_d_i,
    input  logic [4:0]           rs1_addr_e_i,
    input  logic [4:0]           rs2_addr_e_i,
    input  logic [4:0]           rd_addr_e_i,
    input  logic [1:0]           result_src_e_i,
    input  logic                 pc_src_e_i,
    input  logic [4:0]           rd_addr_m_i,
    input  logic                 reg_write_m_i,
    input  logic [4:0]           rd_addr_w_i,
    input  logic                 reg_write_w_i,
    input  logic                 dmem_req_m_i,
    input  logic                 dmem_ready_i,
    output logic                 stall_f_o,
    output logic                 stall_d_o,
    output logic                 stall_e_o,
    output logic                 stall_m_o,
    output logic                 flush_d_o,
    output logic                 flush_e_o,
    output logic                 flush_w_o,
    output logic [1:0]           forward_a_e_o,
    output logic [1:0]           forward_b_e_o,
    output logic                 mem_timeout_o,
    output logic [CNT_WIDTH-1:0] perf_lu_stall_o,
    output logic [CNT_WIDTH-1:0] perf_br_flush_o,
    output logic [CNT_WIDTH-1:0] perf_mem_wait_o
);

    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          unready;
    logic          lu_stall;
    logic          mem_stall;

    assign unready   = dmem_req_m_i && !dmem_ready_i;
    assign lu_stall  = (result_src_e_i == 2'b01) && (rd_addr_e_i != 5'd0) &&
                       ((rd_addr_e_i == rs1_addr_d_i) || (rd_addr_e_i == rs2_addr_d_i));
    assign mem_stall = unready || (state == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (unready) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            WAIT: begin
                if (!unready) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    // Saturate rather than wrap so a disabled timeout never aliases back to zero.
                    if (cnt != CNT_MAX) cnt_nxt = cnt + CW'(1);
                    if ((MEM_TIMEOUT != 0) && ((int'(cnt) + 1) == MEM_TIMEOUT)) state_nxt = ERROR;
                end
            end
            ERROR:   state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_timeout_o = (state == ERROR);

    always_comb begin
        stall_f_o     = 1'b0;
        stall_d_o     = 1'b0;
        stall_e_o     = 1'b0;
        stall_m_o     = 1'b0;
        flush_d_o     = 1'b0;
        flush_e_o     = 1'b0;
        flush_w_o     = 1'b0;
        forward_a_e_o = 2'b00;
        forward_b_e_o = 2'b00;
        if (rst_n) begin
            if (reg_write_m_i && (rd_addr_m_i != 5'd0) && (rd_addr_m_i == rs1_addr_e_i))
                forward_a_e_o = 2'b10;
            else if (reg_write_w_i && (rd_addr_w_i != 5'd0) && (rd_addr_w_i == rs1_addr_e_i))
                forward_a_e_o = 2'b01;
            if (reg_write_m_i && (rd_addr_m_i != 5'd0) && (rd_addr_m_i == rs2_addr_e_i))
                forward_b_e_o = 2'b10;
            else if (reg_write_w_i && (rd_addr_w_i != 5'd0) && (rd_addr_w_i == rs2_addr_e_i))
                forward_b_e_o = 2'b01;

            // A memory freeze holds D/E, so load-use and branch effects resolve after it ends.
            if (mem_stall) begin
                stall_f_o = 1'b1;
                stall_d_o = 1'b1;
                stall_e_o = 1'b1;
                stall_m_o = 1'b1;
                flush_w_o = 1'b1;
            end else begin
                stall_f_o = lu_stall;
                stall_d_o = lu_stall;
                flush_e_o = lu_stall || pc_src_e_i;
                flush_d_o = pc_src_e_i;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] perf_lu, perf_br, perf_mw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu <= '0;
            perf_br <= '0;
            perf_mw <= '0;
        end else begin
            if (lu_stall && !mem_stall && (perf_lu != '1)) perf_lu <= perf_lu + CNT_WIDTH'(1);
            if (pc_src_e_i && !mem_stall && (perf_br != '1)) perf_br <= perf_br + CNT_WIDTH'(1);
            if (mem_stall && (perf_mw != '1)) perf_mw <= perf_mw + CNT_WIDTH'(1);
        end
    end

    assign perf_lu_stall_o = perf_lu;
    assign perf_br_flush_o = perf_br;
    assign perf_mem_wait_o = perf_mw;
`else
    assign perf_lu_stall_o = '0;
    assign perf_br_flush_o = '0;
    assign perf_mem_wait_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed plan steps plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_unit;

    localparam int MEM_T  = 4;
    localparam int CNT_W  = 4;
    localparam int P_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]       rse;
    logic             pc, wm, ww, req, rdy;
    logic             sf, sd, se, sm, fd, fe, fw, mto;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] plu, pbr, pmw;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: consecutive unacknowledged edges, sticky error, perf counts.
    int m_run, m_plu, m_pbr, m_pmw;
    bit m_err;

    hazard_unit #(.MEM_TIMEOUT(MEM_T), .CNT_WIDTH(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr_d_i(rs1d), .rs2_addr_d_i(rs2d),
        .rs1_addr_e_i(rs1e), .rs2_addr_e_i(rs2e), .rd_addr_e_i(rde),
        .result_src_e_i(rse), .pc_src_e_i(pc),
        .rd_addr_m_i(rdm), .reg_write_m_i(wm),
        .rd_addr_w_i(rdw), .reg_write_w_i(ww),
        .dmem_req_m_i(req), .dmem_ready_i(rdy),
        .stall_f_o(sf), .stall_d_o(sd), .stall_e_o(se), .stall_m_o(sm),
        .flush_d_o(fd), .flush_e_o(fe), .flush_w_o(fw),
        .forward_a_e_o(fa), .forward_b_e_o(fb),
        .mem_timeout_o(mto),
        .perf_lu_stall_o(plu), .perf_br_flush_o(pbr), .perf_mem_wait_o(pmw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (wm && rdm != 0 && rdm == src) return 2'b10;
        if (ww && rdw != 0 && rdw == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_lu();
        return (rse == 2'b01) && rde != 0 && (rde == rs1d || rde == rs2d);
    endfunction

    function automatic bit m_ms();
        return m_err || (req && !rdy);
    endfunction

    task automatic set_rst(input logic v);
        rst_n = v;
        if (!v) begin
            m_run = 0; m_err = 0; m_plu = 0; m_pbr = 0; m_pmw = 0;
        end
    endtask

    task automatic idle_inputs();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        rse = 0; pc = 0; wm = 0; ww = 0; req = 0; rdy = 0;
    endtask

    // Sample at the falling edge and compare every output with the model.
    task automatic look(input string tag);
        logic [11:0] e, o;
        bit ms, lu;
        @(negedge clk);
        ms = m_ms();
        lu = m_lu();
        e  = '0;
        if (rst_n) begin
            e[11:8] = ms ? 4'hF : {lu, lu, 2'b00};
            e[7]    = !ms && pc;
            e[6]    = !ms && (lu || pc);
            e[5]    = ms;
            e[4:3]  = m_fwd(rs1e);
            e[2:1]  = m_fwd(rs2e);
            e[0]    = m_err;
        end
        o = {sf, sd, se, sm, fd, fe, fw, fa, fb, mto};
        chk({tag, ".ctrl"}, 32'(o), 32'(e));
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".perf_lu"}, 32'(plu), m_plu);
        chk({tag, ".perf_br"}, 32'(pbr), m_pbr);
        chk({tag, ".perf_mw"}, 32'(pmw), m_pmw);
`else
        chk({tag, ".perf_off"}, 32'({plu, pbr, pmw}), 32'd0);
`endif
    endtask

    // Advance one clock, updating the model with the inputs held across the edge.
    task automatic tick();
        bit ms, lu, unr;
        @(posedge clk);
        if (rst_n) begin
            ms  = m_ms();
            lu  = m_lu();
            unr = req && !rdy;
            if (lu && !ms) m_plu = (m_plu >= P_MAX) ? P_MAX : m_plu + 1;
            if (pc && !ms) m_pbr = (m_pbr >= P_MAX) ? P_MAX : m_pbr + 1;
            if (ms)        m_pmw = (m_pmw >= P_MAX) ? P_MAX : m_pmw + 1;
            m_run = unr ? m_run + 1 : 0;
            if (unr && m_run == MEM_T) m_err = 1;
        end
        #1;
    endtask

    initial begin
        idle_inputs();
        set_rst(1'b0);
        // Hazardous inputs while in reset must still produce quiet outputs.
        rse = 2'b01; rde = 5'd3; rs1d = 5'd3; pc = 1; req = 1;
        rs1e = 5'd2; wm = 1; rdm = 5'd2;
        look("reset");
        chk("reset.stall_f", 32'(sf), 32'd0);
        chk("reset.fwd_a", 32'(fa), 32'd0);
        tick();
        idle_inputs();
        set_rst(1'b1);
        tick();

        // Forwarding priority M > W, then W only, then none.
        rs1e = 5'd5; rs2e = 5'd5; wm = 1; rdm = 5'd5; ww = 1; rdw = 5'd5;
        look("fwd_m");
        chk("fwd_m.a", 32'(fa), 32'b10);
        tick();
        rdm = 5'd0;
        look("fwd_w");
        chk("fwd_w.a", 32'(fa), 32'b01);
        tick();
        wm = 0; rdm = 5'd5;
        look("fwd_w_nowm");
        tick();
        wm = 0; rdw = 5'd0;
        look("fwd_none");
        chk("fwd_none.a", 32'(fa), 32'b00);
        tick();

        // Load-use for one cycle, then the bubble clears it; rd_e = 0 never stalls.
        idle_inputs();
        set_rst(1'b0); tick(); set_rst(1'b1);
        rse = 2'b01; rde = 5'd7; rs2d = 5'd7;
        look("lu");
        chk("lu.stall_f", 32'(sf), 32'd1);
        chk("lu.flush_d", 32'(fd), 32'd0);
        tick();
        rse = 2'b00; rde = 5'd0;
        look("lu_after");
        chk("lu_after.stall_d", 32'(sd), 32'd0);
        tick();
        rse = 2'b01; rde = 5'd0; rs2d = 5'd0;
        look("lu_x0");
        tick();

        // Branch and load-use together.
        idle_inputs();
        set_rst(1'b0); tick(); set_rst(1'b1);
        pc = 1; rse = 2'b01; rde = 5'd9; rs1d = 5'd9;
        look("br_lu");
        chk("br_lu.flush_d", 32'(fd), 32'd1);
        tick();
        idle_inputs();
        look("br_lu_after");
`ifdef HAZARD_PERF_CNT_EN
        chk("br_lu.perf_lu_one", 32'(plu), 32'd1);
        chk("br_lu.perf_br_one", 32'(pbr), 32'd1);
`endif
        tick();

        // Three unacknowledged cycles with a pending branch, then ready.
        req = 1; rdy = 0; pc = 1;
        for (int i = 0; i < 3; i++) begin
            look("mwait");
            chk("mwait.flush_d", 32'(fd), 32'd0);
            tick();
        end
        rdy = 1;
        look("mwait_done");
        chk("mwait_done.flush_e", 32'(fe), 32'd1);
        chk("mwait_done.stall_m", 32'(sm), 32'd0);
        tick();
        req = 0; pc = 0;
        look("mwait_idle");
        tick();

        // Timeout: four unready edges trap; ready no longer releases; reset clears.
        req = 1; rdy = 0;
        for (int i = 0; i < MEM_T; i++) begin
            look("tmo_pre");
            chk("tmo_pre.mto", 32'(mto), 32'd0);
            tick();
        end
        rdy = 1;
        look("tmo_set");
        chk("tmo_set.mto", 32'(mto), 32'd1);
        chk("tmo_set.stall_f", 32'(sf), 32'd1);
        tick();
        for (int i = 0; i < 20; i++) tick();
        look("tmo_sat");
`ifdef HAZARD_PERF_CNT_EN
        chk("tmo_sat.perf_mw_max", 32'(pmw), 32'd15);
`else
        chk("tmo_sat.perf_mw_off", 32'(pmw), 32'd0);
`endif
        tick();
        set_rst(1'b0);
        look("tmo_rst");
        chk("tmo_rst.mto", 32'(mto), 32'd0);
        chk("tmo_rst.stall_f", 32'(sf), 32'd0);
        tick();
        set_rst(1'b1);
        idle_inputs();
        tick();

        // Randomized traffic with small register numbers to provoke matches.
        for (int i = 0; i < 400; i++) begin
            if (m_err && $urandom_range(3) == 0) begin
                set_rst(1'b0);
                look("rnd_rst");
                tick();
                set_rst(1'b1);
            end
            rs1d = 5'($urandom_range(7)); rs2d = 5'($urandom_range(7));
            rs1e = 5'($urandom_range(7)); rs2e = 5'($urandom_range(7));
            rde  = 5'($urandom_range(7)); rdm  = 5'($urandom_range(7));
            rdw  = 5'($urandom_range(7));
            rse  = 2'($urandom_range(3));
            pc   = ($urandom_range(3) == 0);
            wm   = 1'($urandom_range(1));
            ww   = 1'($urandom_range(1));
            req  = ($urandom_range(2) == 0);
            rdy  = ($urandom_range(3) != 0);
            look("rnd");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
